// File: rtl/dyn_branch_predictor_if.sv
// Fetch-side lookup and execute-side update bundle for dyn_branch_predictor.
// The master drives PCs and resolved outcomes; the slave returns predictions and redirects.
interface dyn_branch_predictor_if #(
    parameter int STAT_W = 16
);
    logic [31:0]       if_pc;
    logic              pred_taken;
    logic [31:0]       pred_pc;
    logic              stall;
    logic              upd_valid;
    logic [31:0]       upd_pc;
    logic              upd_is_branch;
    logic              upd_uncond;
    logic              upd_taken;
    logic [31:0]       upd_target;
    logic              upd_pred_taken;
    logic [31:0]       upd_pred_pc;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic [STAT_W-1:0] stat_branches;
    logic [STAT_W-1:0] stat_mispred;

    modport master (
        output if_pc, stall, upd_valid, upd_pc, upd_is_branch, upd_uncond,
               upd_taken, upd_target, upd_pred_taken, upd_pred_pc,
        input  pred_taken, pred_pc, redirect, redirect_pc, stat_branches, stat_mispred
    );

    modport slave (
        input  if_pc, stall, upd_valid, upd_pc, upd_is_branch, upd_uncond,
               upd_taken, upd_target, upd_pred_taken, upd_pred_pc,
        output pred_taken, pred_pc, redirect, redirect_pc, stat_branches, stat_mispred
    );
endinterface

// File: rtl/dyn_branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: zero-latency fetch prediction,
// trained by execute-stage resolution, with mispredict redirect and saturating statistics.
module dyn_branch_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 8,
    parameter int PRED_MODE  = 1,
    parameter int STAT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dyn_branch_predictor_if.slave  bp
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_LO  = INDEX_BITS + 2;
    localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;

    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic                uncond_q [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];

    logic [STAT_W-1:0]   branches_q;
    logic [STAT_W-1:0]   mispred_q;

    logic [INDEX_BITS-1:0] lk_idx;
    logic [TAG_BITS-1:0]   lk_tag;
    logic                  lk_hit;
    logic                  lk_dir;

    logic [INDEX_BITS-1:0] up_idx;
    logic [TAG_BITS-1:0]   up_tag;
    logic                  up_hit;
    logic                  upd_en;
    logic                  mispred;

    // Lookup reads stored state only, so a same-cycle update is not bypassed.
    always_comb begin
        lk_idx = bp.if_pc[INDEX_BITS+1:2];
        lk_tag = bp.if_pc[TAG_HI:TAG_LO];
        lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        if (PRED_MODE != 0) begin
            lk_dir = uncond_q[lk_idx] || ctr_q[lk_idx][1];
        end else begin
            lk_dir = uncond_q[lk_idx];
        end
        bp.pred_taken = lk_hit && lk_dir;
        bp.pred_pc    = bp.pred_taken ? target_q[lk_idx] : bp.if_pc + 32'd4;
    end

    always_comb begin
        up_idx  = bp.upd_pc[INDEX_BITS+1:2];
        up_tag  = bp.upd_pc[TAG_HI:TAG_LO];
        up_hit  = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        upd_en  = bp.upd_valid && !bp.stall && rst_n;
        mispred = upd_en &&
                  ((bp.upd_is_branch &&
                    ((bp.upd_taken != bp.upd_pred_taken) ||
                     (bp.upd_taken && (bp.upd_target != bp.upd_pred_pc)))) ||
                   (!bp.upd_is_branch && bp.upd_pred_taken));
        bp.redirect    = mispred;
        bp.redirect_pc = '0;
        if (mispred) begin
            bp.redirect_pc = bp.upd_taken ? bp.upd_target : bp.upd_pc + 32'd4;
        end
        bp.stat_branches = branches_q;
        bp.stat_mispred  = mispred_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                uncond_q[i] <= 1'b0;
                ctr_q[i]    <= 2'b01;
            end
            branches_q <= '0;
            mispred_q  <= '0;
        end else begin
            if (upd_en) begin
                if (bp.upd_is_branch) begin
                    if (up_hit) begin
                        if (bp.upd_taken) begin
                            if (ctr_q[up_idx] != 2'b11) ctr_q[up_idx] <= ctr_q[up_idx] + 2'd1;
                            target_q[up_idx] <= bp.upd_target;
                            uncond_q[up_idx] <= bp.upd_uncond;
                        end else if (ctr_q[up_idx] != 2'b00) begin
                            ctr_q[up_idx] <= ctr_q[up_idx] - 2'd1;
                        end
                    end else if (bp.upd_taken) begin
                        valid_q[up_idx]  <= 1'b1;
                        tag_q[up_idx]    <= up_tag;
                        target_q[up_idx] <= bp.upd_target;
                        uncond_q[up_idx] <= bp.upd_uncond;
                        ctr_q[up_idx]    <= 2'b10;
                    end
                end else if (up_hit) begin
                    // A non-branch hitting the BTB means the entry aliased; drop it.
                    valid_q[up_idx] <= 1'b0;
                end
                if (bp.upd_is_branch && (branches_q != '1)) begin
                    branches_q <= branches_q + 1'b1;
                end
            end
            if (mispred && (mispred_q != '1)) begin
                mispred_q <= mispred_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dyn_branch_predictor.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_dyn_branch_predictor;
    logic clk;
    logic rst_n;

    dyn_branch_predictor_if #(.STAT_W(16)) ia ();
    dyn_branch_predictor_if #(.STAT_W(16)) ib ();

    dyn_branch_predictor #(.INDEX_BITS(6), .TAG_BITS(8), .PRED_MODE(1), .STAT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bp(ia.slave)
    );
    dyn_branch_predictor #(.INDEX_BITS(6), .TAG_BITS(8), .PRED_MODE(0), .STAT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .bp(ib.slave)
    );

    typedef struct {
        string       name;
        bit          sel;
        bit          pred_taken;
        logic [31:0] pred_pc;
        bit          redirect;
        logic [31:0] redirect_pc;
        bit          chk_stat;
        logic [15:0] sb;
        logic [15:0] sm;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    exp_t        m_e;
    logic        m_pt, m_rd;
    logic [31:0] m_pp, m_rp;
    logic [15:0] m_sb, m_sm;

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            m_e = exp_q.pop_front();
            if (!m_e.sel) begin
                m_pt = ia.pred_taken; m_pp = ia.pred_pc; m_rd = ia.redirect; m_rp = ia.redirect_pc;
                m_sb = ia.stat_branches; m_sm = ia.stat_mispred;
            end else begin
                m_pt = ib.pred_taken; m_pp = ib.pred_pc; m_rd = ib.redirect; m_rp = ib.redirect_pc;
                m_sb = ib.stat_branches; m_sm = ib.stat_mispred;
            end
            check({m_e.name, ".pred_taken"}, {31'd0, m_pt}, {31'd0, m_e.pred_taken});
            check({m_e.name, ".pred_pc"}, m_pp, m_e.pred_pc);
            check({m_e.name, ".redirect"}, {31'd0, m_rd}, {31'd0, m_e.redirect});
            check({m_e.name, ".redirect_pc"}, m_rp, m_e.redirect_pc);
            if (m_e.chk_stat) begin
                check({m_e.name, ".stat_branches"}, {16'd0, m_sb}, {16'd0, m_e.sb});
                check({m_e.name, ".stat_mispred"}, {16'd0, m_sm}, {16'd0, m_e.sm});
            end
        end
    end

    task automatic expect_v(input string n, input bit sel, input bit pt, input logic [31:0] pp,
                            input bit rd, input logic [31:0] rp,
                            input bit cs, input logic [15:0] sb, input logic [15:0] sm);
        exp_t e;
        e.name = n; e.sel = sel; e.pred_taken = pt; e.pred_pc = pp;
        e.redirect = rd; e.redirect_pc = rp; e.chk_stat = cs; e.sb = sb; e.sm = sm;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic upd_a(input bit v, input logic [31:0] pc, input bit br, input bit unc, input bit tk,
                         input logic [31:0] tgt, input bit ptk, input logic [31:0] ppc);
        ia.upd_valid = v; ia.upd_pc = pc; ia.upd_is_branch = br; ia.upd_uncond = unc;
        ia.upd_taken = tk; ia.upd_target = tgt; ia.upd_pred_taken = ptk; ia.upd_pred_pc = ppc;
    endtask

    task automatic upd_b(input bit v, input logic [31:0] pc, input bit br, input bit unc, input bit tk,
                         input logic [31:0] tgt, input bit ptk, input logic [31:0] ppc);
        ib.upd_valid = v; ib.upd_pc = pc; ib.upd_is_branch = br; ib.upd_uncond = unc;
        ib.upd_taken = tk; ib.upd_target = tgt; ib.upd_pred_taken = ptk; ib.upd_pred_pc = ppc;
    endtask

    initial begin
        rst_n = 1'b0;
        ia.stall = 1'b0; ib.stall = 1'b0;
        ia.if_pc = 32'h0040_0010; ib.if_pc = 32'h0040_0010;
        upd_a(1'b1, 32'h0040_0080, 1'b1, 1'b0, 1'b1, 32'h0040_0300, 1'b0, 32'h0040_0084);
        upd_b(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        // Update during reset must neither redirect nor allocate.
        expect_v("reset_cycle", 0, 0, 32'h0040_0014, 0, 32'h0, 1, 16'd0, 16'd0);
        step();
        rst_n = 1'b1;
        upd_a(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_v("after_reset", 0, 0, 32'h0040_0014, 0, 32'h0, 1, 16'd0, 16'd0);
        expect_v("after_reset_b", 1, 0, 32'h0040_0014, 0, 32'h0, 1, 16'd0, 16'd0);
        step();
        ia.if_pc = 32'h0040_0080;
        expect_v("reset_drop", 0, 0, 32'h0040_0084, 0, 32'h0, 1, 16'd0, 16'd0);
        step();

        ia.if_pc = 32'h0040_0020;
        upd_a(1'b1, 32'h0040_0020, 1'b1, 1'b0, 1'b1, 32'h0040_0040, 1'b0, 32'h0040_0024);
        expect_v("beq_taken_alloc", 0, 0, 32'h0040_0024, 1, 32'h0040_0040, 1, 16'd0, 16'd0);
        step();
        upd_a(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_v("beq_ctr10", 0, 1, 32'h0040_0040, 0, 32'h0, 1, 16'd1, 16'd1);
        step();
        upd_a(1'b1, 32'h0040_0020, 1'b1, 1'b0, 1'b0, 32'h0040_0040, 1'b1, 32'h0040_0040);
        expect_v("beq_nt1_nobypass", 0, 1, 32'h0040_0040, 1, 32'h0040_0024, 1, 16'd1, 16'd1);
        step();
        upd_a(1'b1, 32'h0040_0020, 1'b1, 1'b0, 1'b0, 32'h0040_0040, 1'b0, 32'h0040_0024);
        expect_v("beq_ctr01", 0, 0, 32'h0040_0024, 0, 32'h0, 1, 16'd2, 16'd2);
        step();
        expect_v("beq_ctr00", 0, 0, 32'h0040_0024, 0, 32'h0, 1, 16'd3, 16'd2);
        step();
        upd_a(1'b1, 32'h0040_0020, 1'b1, 1'b0, 1'b1, 32'h0040_0040, 1'b0, 32'h0040_0024);
        expect_v("beq_taken_from00", 0, 0, 32'h0040_0024, 1, 32'h0040_0040, 1, 16'd4, 16'd2);
        step();
        upd_a(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_v("beq_sat_low", 0, 0, 32'h0040_0024, 0, 32'h0, 1, 16'd5, 16'd3);
        step();

        ia.stall = 1'b1;
        ia.if_pc = 32'h0040_0060;
        upd_a(1'b1, 32'h0040_0060, 1'b1, 1'b0, 1'b1, 32'h0040_0500, 1'b0, 32'h0040_0064);
        expect_v("stall_redirect", 0, 0, 32'h0040_0064, 0, 32'h0, 1, 16'd5, 16'd3);
        step();
        ia.stall = 1'b0;
        upd_a(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_v("stall_hold", 0, 0, 32'h0040_0064, 0, 32'h0, 1, 16'd5, 16'd3);
        step();

        ia.if_pc = 32'h0040_0100;
        upd_a(1'b1, 32'h0040_0100, 1'b1, 1'b1, 1'b1, 32'h0040_0200, 1'b0, 32'h0040_0104);
        expect_v("j_alloc", 0, 0, 32'h0040_0104, 1, 32'h0040_0200, 1, 16'd5, 16'd3);
        step();
        upd_a(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_v("j_hit", 0, 1, 32'h0040_0200, 0, 32'h0, 1, 16'd6, 16'd4);
        step();
        upd_a(1'b1, 32'h0040_0100, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0040_0200);
        expect_v("nonbranch_alias", 0, 1, 32'h0040_0200, 1, 32'h0040_0104, 1, 16'd6, 16'd4);
        step();
        upd_a(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_v("alias_cleared", 0, 0, 32'h0040_0104, 0, 32'h0, 1, 16'd6, 16'd5);
        step();
        upd_a(1'b1, 32'h0040_0100, 1'b1, 1'b1, 1'b1, 32'h0040_0200, 1'b1, 32'h0040_0200);
        expect_v("j_correct", 0, 0, 32'h0040_0104, 0, 32'h0, 1, 16'd6, 16'd5);
        step();
        upd_a(1'b1, 32'h0040_0100, 1'b1, 1'b1, 1'b1, 32'h0040_0200, 1'b1, 32'h0040_0204);
        expect_v("j_wrong_target", 0, 1, 32'h0040_0200, 1, 32'h0040_0200, 1, 16'd7, 16'd5);
        step();
        upd_a(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_v("a_stats", 0, 1, 32'h0040_0200, 0, 32'h0, 1, 16'd8, 16'd6);
        step();

        ib.if_pc = 32'h0040_0030;
        upd_b(1'b1, 32'h0040_0030, 1'b1, 1'b0, 1'b1, 32'h0040_0050, 1'b0, 32'h0040_0034);
        expect_v("m0_bne_alloc", 1, 0, 32'h0040_0034, 1, 32'h0040_0050, 1, 16'd0, 16'd0);
        step();
        upd_b(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_v("m0_bne_static_nt", 1, 0, 32'h0040_0034, 0, 32'h0, 1, 16'd1, 16'd1);
        step();
        ib.if_pc = 32'h0040_0100;
        upd_b(1'b1, 32'h0040_0100, 1'b1, 1'b1, 1'b1, 32'h0040_0200, 1'b0, 32'h0040_0104);
        expect_v("m0_j_alloc", 1, 0, 32'h0040_0104, 1, 32'h0040_0200, 1, 16'd1, 16'd1);
        step();
        upd_b(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_v("m0_j_taken", 1, 1, 32'h0040_0200, 0, 32'h0, 1, 16'd2, 16'd2);
        step();

        // Non-branch miss with a stale taken prediction: mispredicts without touching the table.
        upd_a(1'b1, 32'h0040_0400, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0040_0200);
        for (int i = 0; i < 65529; i++) step();
        expect_v("mispred_reach_max", 0, 1, 32'h0040_0200, 1, 32'h0040_0404, 1, 16'd8, 16'hFFFF);
        step();
        upd_a(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_v("mispred_saturated", 0, 1, 32'h0040_0200, 0, 32'h0, 1, 16'd8, 16'hFFFF);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dyn_branch_predictor.md
# dyn_branch_predictor

Parametrised dynamic branch predictor for the MIPS pipeline. It replaces execute-stage-only branch resolution with a fetch-stage prediction from a direct-mapped branch target buffer (BTB) carrying 2-bit saturating counters. It is trained by the resolved outcome from the execute stage and reports mispredict redirects plus saturating statistics. It sits between the PC register (lookup side) and the execute-stage branch resolution logic (update side).

## Interface
- INDEX_BITS, 6, log2 of BTB entry count (64 entries)
- TAG_BITS, 8, tag width stored per entry
- PRED_MODE, 1, 0 = static not-taken for conditional branches (BTB used only for unconditional jumps), 1 = 2-bit dynamic
- STAT_W, 16, width of statistics counters
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- if_pc  input  32  fetch-stage PC to predict
- pred_taken  output  1  prediction for if_pc (combinational from stored state)
- pred_pc  output  32  predicted next PC
- stall  input  1  pipeline stall; blocks all updates and counting
- upd_valid  input  1  execute stage holds a resolved instruction
- upd_pc  input  32  PC of resolved instruction
- upd_is_branch  input  1  instruction is beq/bne/bgez/j/jal/jr/jalr
- upd_uncond  input  1  instruction is j/jal/jr/jalr
- upd_taken  input  1  resolved direction
- upd_target  input  32  resolved target
- upd_pred_taken  input  1  prediction made for this instruction at fetch (piped down)
- upd_pred_pc  input  32  predicted next PC made at fetch (piped down)
- redirect  output  1  mispredict, flush younger stages
- redirect_pc  output  32  correct next PC
- stat_branches  output  STAT_W  resolved branch count
- stat_mispred  output  STAT_W  mispredict count

## Operation
- Index = pc[INDEX_BITS+1:2]; tag = pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2].
- Each entry holds valid, tag, target[31:0], uncond, ctr[1:0].
- Lookup: hit = valid && tag match at index(if_pc).
- Lookup, PRED_MODE=1: pred_taken = hit && (uncond || ctr[1]).
- Lookup, PRED_MODE=0: pred_taken = hit && uncond.
- pred_pc = pred_taken ? target : if_pc+4 (mod 2^32).
- Update condition: upd_valid && !stall && rst_n.
  - branch, hit: ctr increments if taken (saturate at 11), decrements if not (saturate at 00); target and uncond overwritten on taken only.
  - branch, miss, taken: allocate/replace the entry at the index: valid=1, tag, target, uncond, ctr=10.
  - branch, miss, not taken: no allocation.
  - non-branch, hit: valid cleared (aliasing cleanup).
- Mispredict = update condition && upd_is_branch && (upd_taken != upd_pred_taken || (upd_taken && upd_target != upd_pred_pc)).
  - Also a mispredict: non-branch with upd_pred_taken=1.
- redirect = mispredict, combinational; redirect_pc = upd_taken ? upd_target : upd_pc+4; 0 when redirect=0.
- stat_branches increments on update condition && upd_is_branch; stat_mispred increments on mispredict. Both saturate at all-ones, no wrap.

## Timing
- Reset (rst_n=0 at an edge): all valid=0, all ctr=01, target/tag=0, both statistics counters=0. Outputs after reset: pred_taken=0, pred_pc=if_pc+4, redirect=0.
- An update presented in a cycle with rst_n=0 is dropped; reset wins.
- Lookup latency 0 cycles against state. Updates visible to lookup the cycle after the edge.
- Lookup and update to the same index in the same cycle: lookup returns pre-update contents; no bypass.
- stall=1: table and counters hold; redirect forced 0.
- Tag aliasing across distinct PCs at the same index and tag is accepted behaviour.

## Test plan
- Reset, then if_pc=0x0040_0010 -> pred_taken=0, pred_pc=0x0040_0014, both stats 0.
- Taken beq at 0x0040_0020, target 0x0040_0040, upd_pred_taken=0 -> redirect=1, redirect_pc=0x0040_0040, stat_mispred=1. Next cycle, lookup 0x0040_0020 -> pred_taken=1, pred_pc=0x0040_0040 (ctr=10).
- Same branch resolved not-taken twice -> ctr 10 -> 01 -> 00; pred_taken=0 after the first. A third not-taken keeps ctr at 00.
- PRED_MODE=0: taken bne allocated -> lookup still pred_taken=0. A j at 0x0040_0100 to 0x0040_0200 -> predicted taken after one update.
- stall=1 with a valid mispredicting update -> redirect=0, table and stats unchanged. Update in a cycle with rst_n=0 -> no entry allocated.
- Force stat_mispred to reach 0xFFFF with STAT_W=16, then one more mispredict -> stays 0xFFFF.
